// File: rtl/present_pkg.sv
// Shared definitions for the PRESENT-80 S-box layer: widths, state types,
// FSM state enum and the pLayer bit permutation.
package present_pkg;

    localparam int STATE_W = 64;
    localparam int NIB_W   = 4;
    localparam int NUM_NIB = 16;

    typedef logic [STATE_W-1:0] state_t;

    // Nibble-array view of the state: element i is bits [4i+3:4i].
    typedef logic [NUM_NIB-1:0][NIB_W-1:0] nib_arr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } sbl_state_e;

    // pLayer: bit i moves to (16*i) mod 63 for i < 63; bit 63 stays in place.
    function automatic state_t player(input state_t s);
        state_t p;
        p = '0;
        for (int i = 0; i < STATE_W - 1; i++) begin
            p[(16 * i) % 63] = s[i];
        end
        p[63] = s[63];
        return p;
    endfunction

endpackage

// File: rtl/present_sbox_layer_seq_if.sv
// Valid/ready bundle between the upstream state source, the S-box layer and
// the downstream consumer. master drives the inputs, slave is the S-box layer.
interface present_sbox_layer_seq_if;
    import present_pkg::*;

    logic   in_valid;
    logic   in_ready;
    state_t in_state;
    state_t in_key;
    logic   out_valid;
    logic   out_ready;
    state_t out_state;
    logic   busy;

    modport master (
        output in_valid, in_state, in_key, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    modport slave (
        input  in_valid, in_state, in_key, out_ready,
        output in_ready, out_valid, out_state, busy
    );

endinterface

// File: rtl/present_sbox_layer_seq_sbox.sv
// PRESENT 4-bit S-box, purely combinational.
module present_sbox_layer_seq_sbox (
    input  logic [3:0] orig,
    output logic [3:0] substituted
);

    // Table lookup of the PRESENT S-box.
    always_comb begin
        // NOTE: every case arm assigns and a default exists, so no latch is inferred.
        unique case (orig)
            4'h0: substituted = 4'hC;
            4'h1: substituted = 4'h5;
            4'h2: substituted = 4'h6;
            4'h3: substituted = 4'hB;
            4'h4: substituted = 4'h9;
            4'h5: substituted = 4'h0;
            4'h6: substituted = 4'hA;
            4'h7: substituted = 4'hD;
            4'h8: substituted = 4'h3;
            4'h9: substituted = 4'hE;
            4'hA: substituted = 4'hF;
            4'hB: substituted = 4'h8;
            4'hC: substituted = 4'h4;
            4'hD: substituted = 4'h7;
            4'hE: substituted = 4'h1;
            default: substituted = 4'h2;
        endcase
    end

endmodule

// File: rtl/present_sbox_layer_seq.sv
// PRESENT-80 round front end: addRoundKey, then the S-box layer applied
// LANES nibbles per cycle, LSB nibble first, result handed out over valid/ready.
// Optional feature: define PRESENT_PLAYER_EN to fold the pLayer into the
// output register (latency unchanged).
module present_sbox_layer_seq
    import present_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    present_sbox_layer_seq_if.slave   bus
);

    localparam int NGRP  = NUM_NIB / LANES;
    localparam int IDX_W = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int LOG_L = $clog2(LANES);

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $fatal(1, "present_sbox_layer_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    sbl_state_e       r_state;
    logic [IDX_W-1:0] r_idx;
    state_t           r_work;
    state_t           r_out_state;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             r_busy;

    nib_arr_t         w_work_nib;
    nib_arr_t         w_work_next;
    logic [3:0]       w_nib_base;
    logic             w_last;
    state_t           w_result;
    logic [NIB_W-1:0] w_sbox_in  [LANES];
    logic [NIB_W-1:0] w_sbox_out [LANES];

    assign w_work_nib = r_work;
    assign w_nib_base = 4'(r_idx) << LOG_L;
    assign w_last     = (r_idx == IDX_W'(NGRP - 1));

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_sbox_in[l] = w_work_nib[w_nib_base + 4'(l)];

        present_sbox_layer_seq_sbox u_sbox (
            .orig        (w_sbox_in[l]),
            .substituted (w_sbox_out[l])
        );
    end

    // Work register with the current nibble group replaced by its substitution.
    always_comb begin
        w_work_next = w_work_nib;
        for (int l = 0; l < LANES; l++) begin
            w_work_next[w_nib_base + 4'(l)] = w_sbox_out[l];
        end
    end

`ifdef PRESENT_PLAYER_EN
    assign w_result = player(state_t'(w_work_next));
`else
    assign w_result = state_t'(w_work_next);
`endif

    // Control FSM and datapath registers; all outputs are registered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the work register is reset too, so nothing undefined can ever reach out_state.
            r_state     <= IDLE;
            r_idx       <= '0;
            r_work      <= '0;
            r_out_state <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments only, so every register sees pre-edge values.
            unique case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (bus.in_valid && r_in_ready) begin
                        r_work     <= bus.in_state ^ bus.in_key;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= SUB;
                    end
                end
                SUB: begin
                    r_work <= state_t'(w_work_next);
                    r_idx  <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_out_state <= w_result;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_state = r_out_state;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_present_sbox_layer_seq.sv
// Self-checking bench for present_sbox_layer_seq: directed vector table,
// hold/reset corner cases, LANES sweep and random back-to-back traffic
// against a nibble-table reference model.
module tb_present_sbox_layer_seq;
    import present_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    present_sbox_layer_seq_if m ();
    present_sbox_layer_seq_if sw2 ();
    present_sbox_layer_seq_if sw4 ();
    present_sbox_layer_seq_if sw16 ();

    present_sbox_layer_seq #(.LANES(1))  u_dut   (.clk(clk), .reset(reset), .bus(m));
    present_sbox_layer_seq #(.LANES(2))  u_dut2  (.clk(clk), .reset(reset), .bus(sw2));
    present_sbox_layer_seq #(.LANES(4))  u_dut4  (.clk(clk), .reset(reset), .bus(sw4));
    present_sbox_layer_seq #(.LANES(16)) u_dut16 (.clk(clk), .reset(reset), .bus(sw16));

    // Reference model: nibble table lookup, then pLayer written as
    // "bit j of nibble n goes to position 16*j + n".
    logic [3:0] sbox_tab [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                  4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    function automatic state_t tb_player(input state_t y);
        state_t o = '0;
        for (int n = 0; n < 16; n++)
            for (int j = 0; j < 4; j++)
                o[16 * j + n] = y[4 * n + j];
        return o;
    endfunction

    function automatic state_t final_of(input state_t sbox_only);
`ifdef PRESENT_PLAYER_EN
        return tb_player(sbox_only);
`else
        return sbox_only;
`endif
    endfunction

    function automatic state_t model(input state_t s, input state_t k);
        state_t x = s ^ k;
        state_t y = '0;
        for (int n = 0; n < 16; n++) y[4 * n +: 4] = sbox_tab[x[4 * n +: 4]];
        return final_of(y);
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction on the LANES=1 instance with out_ready held high.
    task automatic do_txn(input state_t s, input state_t k, input state_t e, input string nm);
        int n = 0;
        int lat = 0;
        m.out_ready = 1'b1;
        while (m.in_ready !== 1'b1 && n < 50) begin step(); n++; end
        check({nm, "_in_ready"}, m.in_ready, 1'b1);
        m.in_state = s;
        m.in_key   = k;
        m.in_valid = 1'b1;
        step();
        m.in_valid = 1'b0;
        m.in_state = 'x;
        m.in_key   = 'x;
        check({nm, "_busy_sub"}, m.busy, 1'b1);
        while (m.out_valid !== 1'b1 && lat < 40) begin step(); lat++; end
        check({nm, "_latency"}, lat, 16);
        check({nm, "_out_state"}, m.out_state, e);
        check({nm, "_in_ready_done"}, m.in_ready, 1'b0);
        step();
        check({nm, "_out_valid_after_hs"}, m.out_valid, 1'b0);
        check({nm, "_in_ready_after_hs"}, m.in_ready, 1'b1);
        check({nm, "_busy_after_hs"}, m.busy, 1'b0);
    endtask

    typedef struct {
        state_t s;
        state_t k;
        state_t e_sbox;
        string  nm;
    } vec_t;

    initial begin
        vec_t   vecs [5];
        state_t exp_cc;
        state_t hold_exp;
        state_t qexp [$];
        logic   stray;
        int     n;

        m.in_valid = 1'b0; m.in_state = '0; m.in_key = '0; m.out_ready = 1'b0;
        sw2.in_valid = 1'b0;  sw2.in_state = '0;  sw2.in_key = '0;  sw2.out_ready = 1'b1;
        sw4.in_valid = 1'b0;  sw4.in_state = '0;  sw4.in_key = '0;  sw4.out_ready = 1'b1;
        sw16.in_valid = 1'b0; sw16.in_state = '0; sw16.in_key = '0; sw16.out_ready = 1'b1;

`ifdef PRESENT_PLAYER_EN
        exp_cc = 64'hFFFFFFFF00000000;
`else
        exp_cc = 64'hCCCCCCCCCCCCCCCC;
`endif

        vecs[0] = '{64'h0123456789ABCDEF, 64'h0, 64'hC56B90AD3EF84712, "t1_ref"};
        vecs[1] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hCCCCCCCCCCCCCCCC, "t2_all_f"};
        vecs[2] = '{64'h0, 64'hFEDCBA9876543210, 64'h21748FE3DA09B65C, "key_only"};
        vecs[3] = '{64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 64'hCCCCCCCCCCCCCCCC, "cancel"};
        vecs[4] = '{64'h0, 64'h0, 64'hCCCCCCCCCCCCCCCC, "zero"};

        // Reset state.
        repeat (3) step();
        check("rst_out_valid", m.out_valid, 1'b0);
        check("rst_out_state", m.out_state, 64'h0);
        check("rst_busy", m.busy, 1'b0);
        check("rst_in_ready", m.in_ready, 1'b0);
        reset = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 5; i++) begin
            do_txn(vecs[i].s, vecs[i].k, final_of(vecs[i].e_sbox), vecs[i].nm);
        end
        check("t2_all_f_final", final_of(vecs[1].e_sbox), exp_cc);

        // Downstream stall for 10 cycles in DONE; a new request is ignored.
        m.out_ready = 1'b0;
        n = 0;
        while (m.in_ready !== 1'b1 && n < 50) begin step(); n++; end
        m.in_state = 64'h0123456789ABCDEF; m.in_key = '0; m.in_valid = 1'b1;
        step();
        m.in_valid = 1'b0;
        n = 0;
        while (m.out_valid !== 1'b1 && n < 40) begin step(); n++; end
        check("hold_latency", n, 16);
        hold_exp = final_of(64'hC56B90AD3EF84712);
        m.in_valid = 1'b1;
        m.in_state = 64'hDEADBEEFCAFEF00D;
        m.in_key   = 64'h1111111111111111;
        for (int c = 0; c < 10; c++) begin
            step();
            check("hold_out_state", m.out_state, hold_exp);
            check("hold_out_valid", m.out_valid, 1'b1);
            check("hold_in_ready", m.in_ready, 1'b0);
        end
        m.in_valid = 1'b0;
        m.out_ready = 1'b1;
        step();
        check("hold_release_valid", m.out_valid, 1'b0);
        stray = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (m.out_valid !== 1'b0) stray = 1'b1;
        end
        check("hold_single_handshake", stray, 1'b0);

        // Reset at SUB idx=7, then a fresh transaction.
        n = 0;
        while (m.in_ready !== 1'b1 && n < 50) begin step(); n++; end
        m.in_state = 64'hFFFFFFFFFFFFFFFF; m.in_key = 64'h0123456789ABCDEF; m.in_valid = 1'b1;
        step();
        m.in_valid = 1'b0;
        repeat (7) step();
        reset = 1'b0;
        step();
        check("midrst_out_valid", m.out_valid, 1'b0);
        check("midrst_busy", m.busy, 1'b0);
        check("midrst_out_state", m.out_state, 64'h0);
        check("midrst_in_ready", m.in_ready, 1'b0);
        reset = 1'b1;
        do_txn(64'h0, 64'h0, exp_cc, "t4_after_rst");

        // LANES sweep: all three instances accept on the same edge.
        begin
            int   l2 = 0, l4 = 0, l16 = 0;
            state_t o2 = '0, o4 = '0, o16 = '0;
            state_t e1 = final_of(64'hC56B90AD3EF84712);
            n = 0;
            while (!(sw2.in_ready === 1'b1 && sw4.in_ready === 1'b1 && sw16.in_ready === 1'b1) && n < 50) begin
                step(); n++;
            end
            check("sweep_ready", {sw2.in_ready, sw4.in_ready, sw16.in_ready}, 3'b111);
            sw2.in_state  = 64'h0123456789ABCDEF; sw2.in_key  = '0; sw2.in_valid  = 1'b1;
            sw4.in_state  = 64'h0123456789ABCDEF; sw4.in_key  = '0; sw4.in_valid  = 1'b1;
            sw16.in_state = 64'h0123456789ABCDEF; sw16.in_key = '0; sw16.in_valid = 1'b1;
            step();
            sw2.in_valid = 1'b0; sw4.in_valid = 1'b0; sw16.in_valid = 1'b0;
            for (int c = 1; c <= 20; c++) begin
                step();
                if (sw2.out_valid === 1'b1 && l2 == 0)   begin l2 = c;  o2 = sw2.out_state;  end
                if (sw4.out_valid === 1'b1 && l4 == 0)   begin l4 = c;  o4 = sw4.out_state;  end
                if (sw16.out_valid === 1'b1 && l16 == 0) begin l16 = c; o16 = sw16.out_state; end
            end
            check("sweep_l2_latency", l2, 8);
            check("sweep_l4_latency", l4, 4);
            check("sweep_l16_latency", l16, 1);
            check("sweep_l2_state", o2, e1);
            check("sweep_l4_state", o4, e1);
            check("sweep_l16_state", o16, e1);
        end

        // Random back-to-back traffic with in_valid and out_ready held high.
        begin
            int     n_out = 0;
            int     cyc = 0;
            logic   acc, hs;
            state_t s, k;
            s = {$urandom, $urandom};
            k = {$urandom, $urandom};
            m.in_state = s; m.in_key = k; m.in_valid = 1'b1; m.out_ready = 1'b1;
            while (n_out < 100 && cyc < 4000) begin
                acc = m.in_valid && m.in_ready;
                hs  = m.out_valid && m.out_ready;
                if (hs) begin
                    if (qexp.size() == 0) check("b2b_unexpected_output", 1'b1, 1'b0);
                    else check("b2b_out_state", m.out_state, qexp.pop_front());
                end
                if (acc) qexp.push_back(model(s, k));
                step();
                cyc++;
                if (hs) begin
                    check("b2b_in_ready_after_hs", m.in_ready, 1'b1);
                    n_out++;
                end
                if (acc) begin
                    s = {$urandom, $urandom};
                    k = {$urandom, $urandom};
                    m.in_state = s;
                    m.in_key   = k;
                end
            end
            check("b2b_output_count", n_out, 100);
            m.in_valid = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
